// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Screen geometry, direction/fire-state enums and the shared
//               clamped-step helper used by the game-logic blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRE     = 2'd1,
        COOLDOWN = 2'd2
    } fire_state_t;

    // Moves pos by one step in the requested direction, saturating at 0 and max_pos.
    function automatic logic [COORD_W-1:0] clamp_step(
        input logic [COORD_W-1:0] pos,
        input logic               dec,
        input logic               inc,
        input int                 step,
        input int                 max_pos
    );
        int p;
        p = int'(pos);
        if (dec) begin
            p = (p >= step) ? p - step : 0;
        end else if (inc) begin
            p = (p <= max_pos - step) ? p + step : max_pos;
        end
        return COORD_W'(p);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Free-running divider producing a one-cycle tick every DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 416667
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int                  c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign o_tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
// Module      : player_motion
// Description : Ticked, edge-clamped sprite movement with frame-stable display
//               coordinates, facing, and a rate-limited fire pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module player_motion
    import game_pkg::*;
#(
    parameter int MOVE_DIV       = 416667,
    parameter int STEP           = 2,
    parameter int SPRITE_W       = 32,
    parameter int SPRITE_H       = 32,
    parameter int X_INIT         = 304,
    parameter int Y_INIT         = 224,
    parameter int COOLDOWN_TICKS = 30
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_left,
    input  logic               i_right,
    input  logic               i_fire,
    input  logic               i_frame,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [1:0]         o_dir,
    output logic               o_fire,
    output logic               o_busy
);

    localparam int                 c_x_max   = SCREEN_W - SPRITE_W;
    localparam int                 c_y_max   = SCREEN_H - SPRITE_H;
    localparam int                 c_cd_w    = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
    localparam logic [c_cd_w-1:0]  c_cd_last = c_cd_w'((COOLDOWN_TICKS > 0) ? COOLDOWN_TICKS - 1 : 0);

    logic w_tick;

    tick_gen #(
        .DIV    (MOVE_DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    // Opposing inputs cancel, so each axis moves in at most one direction.
    logic w_go_left, w_go_right, w_go_up, w_go_down;
    assign w_go_left  = i_left  & ~i_right;
    assign w_go_right = i_right & ~i_left;
    assign w_go_up    = i_up    & ~i_down;
    assign w_go_down  = i_down  & ~i_up;

    logic [COORD_W-1:0] r_px, r_py, r_x_disp, r_y_disp;
    logic [COORD_W-1:0] w_px_next, w_py_next;
    dir_t               r_dir, w_dir_next;

    assign w_px_next = clamp_step(r_px, w_go_left, w_go_right, STEP, c_x_max);
    assign w_py_next = clamp_step(r_py, w_go_up,   w_go_down,  STEP, c_y_max);

    always_comb begin
        w_dir_next = r_dir;
        if (w_go_left) begin
            w_dir_next = LEFT;
        end else if (w_go_right) begin
            w_dir_next = RIGHT;
        end else if (w_go_up) begin
            w_dir_next = UP;
        end else if (w_go_down) begin
            w_dir_next = DOWN;
        end
    end

    // The display copy samples px/py before any same-cycle tick update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_px     <= COORD_W'(X_INIT);
            r_py     <= COORD_W'(Y_INIT);
            r_x_disp <= COORD_W'(X_INIT);
            r_y_disp <= COORD_W'(Y_INIT);
            r_dir    <= UP;
        end else begin
            if (w_tick) begin
                r_px  <= w_px_next;
                r_py  <= w_py_next;
                r_dir <= w_dir_next;
            end
            if (i_frame) begin
                r_x_disp <= r_px;
                r_y_disp <= r_py;
            end
        end
    end

    fire_state_t       r_state, w_state_next;
    logic [c_cd_w-1:0] r_cd, w_cd_next;
    logic              r_fire_prev;
    logic              w_fire_edge;

    assign w_fire_edge = i_fire & ~r_fire_prev;

    // fire_prev resets high so a button held through reset cannot fire.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cd        <= '0;
            r_fire_prev <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_cd        <= w_cd_next;
            r_fire_prev <= i_fire;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cd_next    = r_cd;
        case (r_state)
            IDLE: begin
                if (w_fire_edge) begin
                    w_state_next = FIRE;
                end
            end
            FIRE: begin
                w_cd_next    = '0;
                w_state_next = (COOLDOWN_TICKS == 0) ? IDLE : COOLDOWN;
            end
            COOLDOWN: begin
                if (w_tick) begin
                    if (r_cd == c_cd_last) begin
                        w_state_next = IDLE;
                        w_cd_next    = '0;
                    end else begin
                        w_cd_next = r_cd + c_cd_w'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cd_next    = '0;
            end
        endcase
    end

    assign o_x    = r_x_disp;
    assign o_y    = r_y_disp;
    assign o_dir  = r_dir;
    assign o_fire = (r_state == FIRE);
    assign o_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_player_motion.sv
`default_nettype none
// ============================================================================
// Module      : tb_player_motion
// Description : Directed bench for player_motion, two instances with different
//               start positions checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_motion;

    localparam int MOVE_DIV = 4;
    localparam int STEP     = 2;
    localparam int CD_TICKS = 3;
    localparam int X_MAX    = 640 - 32;
    localparam int Y_MAX    = 480 - 32;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic up    = 1'b0;
    logic down  = 1'b0;
    logic left  = 1'b0;
    logic right = 1'b0;
    logic fire  = 1'b0;
    logic frame = 1'b0;

    logic [9:0] ox   [2];
    logic [9:0] oy   [2];
    logic [1:0] odir [2];
    logic       ofire[2];
    logic       obusy[2];

    int xinit[2] = '{304, 1};
    int yinit[2] = '{224, 447};

    always #5 clk = ~clk;

    player_motion #(
        .MOVE_DIV(MOVE_DIV), .STEP(STEP), .SPRITE_W(32), .SPRITE_H(32),
        .X_INIT(304), .Y_INIT(224), .COOLDOWN_TICKS(CD_TICKS)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_left(left),
        .i_right(right), .i_fire(fire), .i_frame(frame),
        .o_x(ox[0]), .o_y(oy[0]), .o_dir(odir[0]), .o_fire(ofire[0]), .o_busy(obusy[0])
    );

    player_motion #(
        .MOVE_DIV(MOVE_DIV), .STEP(STEP), .SPRITE_W(32), .SPRITE_H(32),
        .X_INIT(1), .Y_INIT(447), .COOLDOWN_TICKS(CD_TICKS)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_up(up), .i_down(down), .i_left(left),
        .i_right(right), .i_fire(fire), .i_frame(frame),
        .o_x(ox[1]), .o_y(oy[1]), .o_dir(odir[1]), .o_fire(ofire[1]), .o_busy(obusy[1])
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampi(input int val, input int hi);
        return (val < 0) ? 0 : ((val > hi) ? hi : val);
    endfunction

    // Behavioural model: cycle count since reset, integer positions, and a
    // shot phase with a countdown of ticks left in cooldown.
    int m_cnt, m_phase, m_left, m_h, m_v;
    int m_px[2], m_py[2], m_ox[2], m_oy[2], m_dir[2];
    bit m_prev, m_tick, m_edge;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt   = 0;
            m_phase = 0;
            m_left  = 0;
            m_prev  = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_px[i] = xinit[i]; m_ox[i] = xinit[i];
                m_py[i] = yinit[i]; m_oy[i] = yinit[i];
                m_dir[i] = 0;
            end
            m_valid = 1'b1;
        end else begin
            m_tick = (m_cnt % MOVE_DIV) == MOVE_DIV - 1;
            m_cnt  = m_cnt + 1;
            m_h    = int'(right) - int'(left);
            m_v    = int'(down) - int'(up);
            for (int i = 0; i < 2; i++) begin
                if (frame) begin
                    m_ox[i] = m_px[i];
                    m_oy[i] = m_py[i];
                end
                if (m_tick) begin
                    m_px[i] = clampi(m_px[i] + m_h * STEP, X_MAX);
                    m_py[i] = clampi(m_py[i] + m_v * STEP, Y_MAX);
                    if (m_h != 0)      m_dir[i] = (m_h < 0) ? 2 : 3;
                    else if (m_v != 0) m_dir[i] = (m_v < 0) ? 0 : 1;
                end
            end
            m_edge = fire && !m_prev;
            m_prev = fire;
            case (m_phase)
                0: if (m_edge) m_phase = 1;
                1: begin
                    m_left  = CD_TICKS;
                    m_phase = (CD_TICKS == 0) ? 0 : 2;
                end
                default: if (m_tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 0;
                end
            endcase
        end
    end

    int pulses = 0;

    always @(negedge clk) begin
        if (ofire[0]) pulses++;
        if (m_valid) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("x[%0d]", i),    int'(ox[i]),    m_ox[i]);
                check($sformatf("y[%0d]", i),    int'(oy[i]),    m_oy[i]);
                check($sformatf("dir[%0d]", i),  int'(odir[i]),  m_dir[i]);
                check($sformatf("fire[%0d]", i), int'(ofire[i]), int'(m_phase == 1));
                check($sformatf("busy[%0d]", i), int'(obusy[i]), int'(m_phase != 0));
            end
        end
    end

    // Cycle index since reset release; i_frame fires when it is 7 mod 8,
    // which lines up with every second tick.
    int cyc = 0;

    task automatic run(input int n, input logic r, input logic u, input logic d,
                       input logic l, input logic rt, input logic f);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst = r; up = u; down = d; left = l; right = rt; fire = f;
            frame = !r && (cyc % 8 == 7);
            cyc = r ? 0 : cyc + 1;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    int p0;

    initial begin
        run(3, 1, 0, 0, 0, 0, 0);
        settle();
        check("reset_x_a", int'(ox[0]), 304);
        check("reset_y_a", int'(oy[0]), 224);
        check("reset_x_b", int'(ox[1]), 1);
        check("reset_dir", int'(odir[0]), 0);
        check("reset_busy", int'(obusy[0]), 0);

        // Right for 5 ticks; the second tick coincides with a frame.
        run(8, 0, 0, 0, 0, 1, 0);
        settle();
        check("coincident_x", int'(ox[0]), 306);
        run(12, 0, 0, 0, 0, 1, 0);
        run(4, 0, 0, 0, 0, 0, 0);
        settle();
        check("right_x_a", int'(ox[0]), 314);
        check("right_x_b", int'(ox[1]), 11);
        check("right_dir", int'(odir[0]), 3);

        // Cancel on x with down, then up+right diagonal.
        run(4, 0, 0, 1, 1, 1, 0);
        settle();
        check("cancel_dir", int'(odir[0]), 1);
        run(4, 0, 1, 0, 0, 1, 0);
        settle();
        check("diag_pre_x", int'(ox[0]), 314);
        check("diag_pre_y", int'(oy[0]), 226);
        check("bottom_clamp_y_b", int'(oy[1]), 448);
        check("diag_dir", int'(odir[0]), 3);
        run(8, 0, 0, 0, 0, 0, 0);
        settle();
        check("diag_x", int'(ox[0]), 316);
        check("diag_y", int'(oy[0]), 224);
        check("diag_x_b", int'(ox[1]), 13);
        check("diag_y_b", int'(oy[1]), 446);

        // Edge clamps.
        run(640, 0, 0, 0, 1, 0, 0);
        run(8, 0, 0, 0, 0, 0, 0);
        settle();
        check("left_clamp_a", int'(ox[0]), 0);
        check("left_clamp_b", int'(ox[1]), 0);
        run(1280, 0, 0, 0, 0, 1, 0);
        run(8, 0, 0, 0, 0, 0, 0);
        settle();
        check("right_clamp_a", int'(ox[0]), 608);
        check("right_clamp_b", int'(ox[1]), 608);

        // Fire, retoggle during cooldown, then fire again.
        p0 = pulses;
        run(1, 0, 0, 0, 0, 0, 1);
        settle();
        check("fire_pulse", int'(ofire[0]), 1);
        check("fire_busy", int'(obusy[0]), 1);
        run(1, 0, 0, 0, 0, 0, 1);
        settle();
        check("fire_one_cycle", int'(ofire[0]), 0);
        check("cooldown_busy", int'(obusy[0]), 1);
        run(2, 0, 0, 0, 0, 0, 0);
        run(2, 0, 0, 0, 0, 0, 1);
        run(16, 0, 0, 0, 0, 0, 0);
        settle();
        check("cooldown_done", int'(obusy[0]), 0);
        check("pulses_after_toggle", pulses - p0, 1);
        run(1, 0, 0, 0, 0, 0, 1);
        settle();
        check("refire", int'(ofire[0]), 1);
        run(16, 0, 0, 0, 0, 0, 0);
        check("pulses_after_refire", pulses - p0, 2);

        // Fire held through reset release must not fire.
        run(3, 1, 0, 0, 0, 0, 1);
        run(20, 0, 0, 0, 0, 0, 1);
        check("held_no_fire", pulses - p0, 2);
        run(1, 0, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0, 0, 1);
        run(4, 0, 0, 0, 0, 0, 0);
        check("held_new_edge", pulses - p0, 3);

        // Reset in the middle of cooldown while moving.
        run(16, 0, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0, 0, 1);
        run(6, 0, 0, 1, 0, 1, 0);
        settle();
        check("midrst_busy_before", int'(obusy[0]), 1);
        run(1, 1, 0, 1, 0, 1, 0);
        settle();
        check("midrst_x_a", int'(ox[0]), 304);
        check("midrst_y_a", int'(oy[0]), 224);
        check("midrst_x_b", int'(ox[1]), 1);
        check("midrst_y_b", int'(oy[1]), 447);
        check("midrst_dir", int'(odir[0]), 0);
        check("midrst_busy", int'(obusy[0]), 0);
        run(16, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_motion.md
# player_motion

Game-logic stage between the joystick front end and the VGA renderer. Consumes debounced joystick direction and fire levels, and moves a player sprite across the 640x480 screen at a fixed tick rate, clamped to the screen edges. Publishes frame-stable sprite coordinates and facing to the renderer, plus a rate-limited fire pulse with cooldown.

## Interface
- MOVE_DIV, 416667: clock cycles per movement tick (120 Hz at 50 MHz); minimum 1.
- STEP, 2: pixels moved per tick per axis; minimum 1.
- SPRITE_W, 32: sprite width in pixels.
- SPRITE_H, 32: sprite height in pixels.
- X_INIT, 304: reset x (top-left corner).
- Y_INIT, 224: reset y (top-left corner).
- COOLDOWN_TICKS, 30: movement ticks spent in cooldown after a shot.

Ports:
- i_clk  in  1  system clock, 50 MHz.
- i_rst  in  1  synchronous reset, active-high.
- i_up, i_down, i_left, i_right  in  1 each  direction levels, active-high, already debounced and synchronous to i_clk.
- i_fire  in  1  fire level, active-high, debounced.
- i_frame  in  1  one-cycle pulse at the start of vertical blanking, from the VGA block.
- o_x  out  10  displayed sprite x; range 0..X_MAX, where X_MAX = 640 - SPRITE_W.
- o_y  out  10  displayed sprite y; range 0..Y_MAX, where Y_MAX = 480 - SPRITE_H.
- o_dir  out  2  facing (dir_t): UP=0, DOWN=1, LEFT=2, RIGHT=3.
- o_fire  out  1  one-cycle shot pulse.
- o_busy  out  1  high while in FIRE or COOLDOWN.

## Operation
- **Tick generator:**
  - Counter runs 0..MOVE_DIV-1 and wraps to 0.
  - tick = 1 in the cycle where count == MOVE_DIV-1.
  - MOVE_DIV=1 gives tick every cycle.
- **Net axis direction:**
  - Horizontal: h = right - left, giving -1, 0 or +1. Vertical: v = down - up.
  - Opposing inputs held together cancel on that axis.
  - Diagonals are allowed.
- **Position update, on tick only:**
  - Internal registers px, py.
  - h = -1: px = (px >= STEP) ? px-STEP : 0.
  - h = +1: px = (px <= X_MAX-STEP) ? px+STEP : X_MAX.
  - py follows the same rule with Y_MAX.
  - No wrap-around; values never leave their range.
- **Facing, on tick only:**
  - If h != 0, dir = LEFT or RIGHT.
  - Else if v != 0, dir = UP or DOWN.
  - Else dir is unchanged.
- **Display buffer:**
  - On i_frame, o_x/o_y load px/py. They hold at all other times.
  - o_dir is direct from its register and is not frame-buffered.
- **Fire FSM** (fire_state_t IDLE, FIRE, COOLDOWN):
  - Edge detect: fire_edge = i_fire & ~fire_prev.
  - IDLE -> FIRE on fire_edge.
  - FIRE -> COOLDOWN unconditionally after one cycle. If COOLDOWN_TICKS = 0, FIRE -> IDLE instead.
  - COOLDOWN: cd counter increments on each tick. Exit to IDLE on the cycle the COOLDOWN_TICKS-th tick is counted.
  - fire_edge outside IDLE is discarded, not queued.
  - A held i_fire never refires; a new rising edge is required.
- **Outputs:**
  - o_fire = (state == FIRE).
  - o_busy = (state != IDLE).

## Timing
- **Reset values** (reset wins over every other event, mid-operation included):
  - count=0.
  - px=o_x=X_INIT, py=o_y=Y_INIT.
  - o_dir=UP.
  - state=IDLE, cd=0, so o_fire=0 and o_busy=0.
  - fire_prev=1, so a button held through reset release does not fire.
- **Movement latency:**
  - Inputs are sampled in the tick cycle; px/py change at the next edge.
  - They become visible on o_x/o_y at the first i_frame after that.
- **tick and i_frame in the same cycle:** o_x/o_y load the pre-update px/py.
- **Fire latency:** i_fire rising, sampled high at edge N with fire_prev low, gives o_fire high for exactly the cycle after edge N.
- **Cooldown timing:**
  - COOLDOWN counts only ticks; a tick in the FIRE cycle is not counted.
  - o_busy stays high from o_fire through the exit cycle.
  - A new edge is accepted at the first cycle in IDLE.

## Structure
- **Package game_pkg:**
  - SCREEN_W=640, SCREEN_H=480.
  - dir_t and fire_state_t enums.
  - Coordinate width constant COORD_W=10.
  - This package is shared with the VGA renderer.
- **Sub-module tick_gen:** parameter DIV; ports i_clk, i_rst, o_tick. Reused by other game blocks.

## Test plan
Bench parameters: MOVE_DIV=4, STEP=2, COOLDOWN_TICKS=3, SPRITE 32x32, X_INIT=304, Y_INIT=224, i_frame every 8 cycles.
- **Right move:** hold i_right for 5 ticks. px goes to 314. o_x = 314 after the next i_frame. o_dir=RIGHT.
- **Left clamp:** start at X_INIT=1 and hold i_left. px goes to 0 and stays 0. Also hold right at px=607. px goes to 608 = X_MAX and stays.
- **Cancel and diagonal:** hold left+right+down for one tick. px is unchanged, py+2, o_dir=DOWN. Then hold up+right: px+2, py-2, o_dir=RIGHT.
- **Fire and cooldown:**
  - Raise i_fire. o_fire pulses for exactly 1 cycle and o_busy rises.
  - Toggle i_fire during cooldown. No second pulse.
  - o_busy falls on the cycle the 3rd tick is counted.
  - A new edge then fires again.
- **Held fire:** hold i_fire high through reset release and beyond. No o_fire until i_fire drops and rises again.
- **Reset mid-motion:** assert i_rst mid-cooldown while moving. Next cycle: o_x=304, o_y=224, o_dir=UP, o_busy=0. Also drive tick and i_frame coincident: o_x takes the pre-update value.
